// File: rtl/ram_be_arbiter.sv
// ram_be_arbiter: arbitrates two requesters onto one byte-enable block RAM.
// The write port and the read port are shared independently, each with its own
// round-robin pointer. Read data returns through a two-entry response FIFO per
// requester, with valid/ready backpressure.
//
// Ports:
//   clk_in, reset_in                     clock, synchronous active-high reset
//   wrValid_in/wrReady_out               per-requester write handshake
//   wrAddr_in/wrData_in/wrByteEn_in      write row, byte lanes 7..0, enables
//   rdValid_in/rdReady_out/rdAddr_in     per-requester read request handshake
//   rspValid_out/rspReady_in/rspData_out per-requester response FIFO head
//
// Optional feature: define RAM_ARB_FWD_EN so that a read accepted in the same
// cycle as a write to the same row returns the newly written bytes.

module ram_sc_be #(
    parameter int unsigned ADDR_NBITS = 5,
    parameter int unsigned SPAN_NBITS = 8,
    parameter int unsigned NSPANS     = 8
) (
    input  logic                                 clk_in,
    input  logic                                 wr_en,
    input  logic [ADDR_NBITS-1:0]                wr_addr,
    input  logic [NSPANS-1:0][SPAN_NBITS-1:0]    wr_data,
    input  logic [NSPANS-1:0]                    wr_be,
    input  logic [ADDR_NBITS-1:0]                rd_addr,
    output logic [NSPANS-1:0][SPAN_NBITS-1:0]    rd_data
);
    localparam int unsigned DEPTH = 1 << ADDR_NBITS;

    logic [NSPANS-1:0][SPAN_NBITS-1:0] mem [DEPTH];

    // Registered read returns pre-write data on a same-row collision.
    always_ff @(posedge clk_in) begin
        for (int j = 0; j < int'(NSPANS); j++) begin
            if (wr_en && wr_be[j]) begin
                mem[wr_addr][j] <= wr_data[j];
            end
        end
        rd_data <= mem[rd_addr];
    end
endmodule

module ram_be_arbiter #(
    parameter int unsigned ADDR_NBITS = 5
) (
    input  logic                            clk_in,
    input  logic                            reset_in,
    input  logic [1:0]                      wrValid_in,
    output logic [1:0]                      wrReady_out,
    input  logic [1:0][ADDR_NBITS-1:0]      wrAddr_in,
    input  logic [1:0][7:0][7:0]            wrData_in,
    input  logic [1:0][7:0]                 wrByteEn_in,
    input  logic [1:0]                      rdValid_in,
    output logic [1:0]                      rdReady_out,
    input  logic [1:0][ADDR_NBITS-1:0]      rdAddr_in,
    output logic [1:0]                      rspValid_out,
    input  logic [1:0]                      rspReady_in,
    output logic [1:0][7:0][7:0]            rspData_out
);
    localparam int unsigned NLANES     = 8;
    localparam int unsigned SPAN_NBITS = 8;

    typedef logic [NLANES-1:0][SPAN_NBITS-1:0] row_t;

    logic            wpri;
    logic            rpri;
    logic            infl_v;
    logic            infl_tag;
    logic [1:0][1:0] fifo_cnt;
    logic [1:0][1:0] occ;
    logic [1:0]      fifo_wptr;
    logic [1:0]      fifo_rptr;
    row_t            fifo_mem [2][2];
    logic [1:0]      rsp_pop;
    logic [1:0]      rsp_push;
    logic [1:0]      rd_elig;
    logic            wr_sel;
    logic            rd_sel;
    logic            ram_wr_en;
    logic            rd_fire;
    row_t            ram_rd_data;
    row_t            push_data;

    // Occupancy counts the in-flight read so an accepted read always has a slot.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rsp_pop[i]  = (fifo_cnt[i] != 2'd0) && rspReady_in[i];
            rsp_push[i] = infl_v && (infl_tag == 1'(i));
            occ[i]      = fifo_cnt[i] + 2'(rsp_push[i]);
            rd_elig[i]  = rdValid_in[i] &&
                          ((occ[i] < 2'd2) || ((occ[i] == 2'd2) && rsp_pop[i]));
        end
    end

    // Round-robin grants; the pointer only matters when both are eligible.
    always_comb begin
        wrReady_out = 2'b00;
        rdReady_out = 2'b00;
        if (!reset_in) begin
            if (&wrValid_in) wrReady_out[wpri] = 1'b1;
            else             wrReady_out       = wrValid_in;
            if (&rd_elig)    rdReady_out[rpri] = 1'b1;
            else             rdReady_out       = rd_elig;
        end
    end

    assign wr_sel    = wrReady_out[1];
    assign ram_wr_en = |wrReady_out;
    assign rd_sel    = rdReady_out[1];
    assign rd_fire   = |rdReady_out;

    ram_sc_be #(
        .ADDR_NBITS (ADDR_NBITS),
        .SPAN_NBITS (SPAN_NBITS),
        .NSPANS     (NLANES)
    ) u_ram (
        .clk_in  (clk_in),
        .wr_en   (ram_wr_en),
        .wr_addr (wrAddr_in[wr_sel]),
        .wr_data (wrData_in[wr_sel]),
        .wr_be   (wrByteEn_in[wr_sel]),
        .rd_addr (rdAddr_in[rd_sel]),
        .rd_data (ram_rd_data)
    );

`ifdef RAM_ARB_FWD_EN
    row_t              fwd_data;
    logic [NLANES-1:0] fwd_be;
    logic              fwd_hit;

    // Capture the colliding write so its enabled bytes override the stale RAM read.
    always_ff @(posedge clk_in) begin
        fwd_data <= wrData_in[wr_sel];
        fwd_be   <= wrByteEn_in[wr_sel];
        if (reset_in) begin
            fwd_hit <= 1'b0;
        end else begin
            fwd_hit <= ram_wr_en && rd_fire &&
                       (wrAddr_in[wr_sel] == rdAddr_in[rd_sel]);
        end
    end

    always_comb begin
        for (int j = 0; j < int'(NLANES); j++) begin
            push_data[j] = (fwd_hit && fwd_be[j]) ? fwd_data[j] : ram_rd_data[j];
        end
    end
`else
    assign push_data = ram_rd_data;
`endif

    // Pointers, in-flight tag and FIFO bookkeeping.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            wpri      <= 1'b0;
            rpri      <= 1'b0;
            infl_v    <= 1'b0;
            infl_tag  <= 1'b0;
            fifo_cnt  <= '0;
            fifo_wptr <= '0;
            fifo_rptr <= '0;
        end else begin
            if (&wrValid_in) wpri <= ~wpri;
            if (&rd_elig)    rpri <= ~rpri;
            infl_v   <= rd_fire;
            infl_tag <= rd_sel;
            for (int i = 0; i < 2; i++) begin
                if (rsp_push[i]) fifo_wptr[i] <= ~fifo_wptr[i];
                if (rsp_pop[i])  fifo_rptr[i] <= ~fifo_rptr[i];
                fifo_cnt[i] <= fifo_cnt[i] + 2'(rsp_push[i]) - 2'(rsp_pop[i]);
            end
        end
    end

    // FIFO storage needs no reset; the counters gate visibility.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_in && rsp_push[i]) begin
                fifo_mem[i][fifo_wptr[i]] <= push_data;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rspValid_out[i] = (fifo_cnt[i] != 2'd0);
            rspData_out[i]  = fifo_mem[i][fifo_rptr[i]];
        end
    end
endmodule

// File: doc/ram_be_arbiter.md
# ram_be_arbiter

Two-requester arbiter and sequencer in front of one 32×64-bit single-clock byte-enable block RAM (an internal `ram_sc_be` instance, `SPAN_NBITS` = 8). It shares the RAM's write port and read port independently between requester 0 and requester 1, using round-robin arbitration on each port. Read data returns through a per-requester two-entry response FIFO with valid/ready backpressure. Typical use: a PCIe TLP write/read engine on one side, and a register/DMA sequencer on the other, sharing a completion or scratch buffer.

## Interface
- `ADDR_NBITS`, default 5: RAM address width; depth is 2^`ADDR_NBITS` rows of 8 bytes.
- `clk_in`  in  1  sole clock.
- `reset_in`  in  1  synchronous, active-high reset.
- `wrValid_in`  in  [1:0]  write request, one bit per requester.
- `wrReady_out`  out  [1:0]  write accepted this cycle (grant).
- `wrAddr_in`  in  [1:0][ADDR_NBITS-1:0]  write row address.
- `wrData_in`  in  [1:0][7:0][7:0]  write data, byte lanes 7..0.
- `wrByteEn_in`  in  [1:0][7:0]  byte enables. All-zero is legal: the request is accepted but nothing changes.
- `rdValid_in`  in  [1:0]  read request.
- `rdReady_out`  out  [1:0]  read request accepted this cycle.
- `rdAddr_in`  in  [1:0][ADDR_NBITS-1:0]  read row address.
- `rspValid_out`  out  [1:0]  response FIFO head valid.
- `rspReady_in`  in  [1:0]  response consumed when valid and ready are both high.
- `rspData_out`  out  [1:0][7:0][7:0]  response FIFO head data.

## Operation
- **Transfer rule:** a transfer occurs on any channel when valid and ready are high at a rising edge. Requesters hold valid, address and data stable until accepted.
- **Write arbitration:**
  - Requester *i* is eligible when `wrValid_in[i]` is high.
  - One eligible requester gets the grant. If both are eligible, the requester named by the write-priority pointer `wpri` gets it.
  - After a contended grant, `wpri` moves to the loser. Uncontended grants leave `wpri` unchanged.
  - The granted write is presented to the RAM combinationally and commits at that edge, honouring the byte enables.
- **Read arbitration:**
  - Occupancy `occ[i]` = response FIFO entries + in-flight read (0/1). Range is 0..2.
  - Requester *i* is eligible when `rdValid_in[i]` is high and either `occ[i]` < 2, or `occ[i]` == 2 and a pop occurs this cycle.
  - Arbitration is round-robin with a separate pointer `rpri`, using the same pointer rule as writes.
  - The granted address goes to the RAM read port. A one-bit tag plus valid is registered alongside it. On the next edge the RAM output is pushed into the tagged requester's FIFO.
- **Response FIFO:** two entries, FIFO order. `rspValid_out[i]` = FIFO *i* non-empty. Push and pop may occur in the same cycle. The occupancy rule guarantees the FIFO never overflows.
- **Read during write:** a same-row read and write in the same cycle return pre-write data. `RAM_ARB_FWD_EN` changes this; see Configuration.
- **Ready paths:** `wrReady_out` and `rdReady_out` are combinational from the valid inputs, the pointers and `occ`. `rdReady_out` also depends combinationally on `rspReady_in`. Neither ready output depends on its own valid input being sampled as low.
- **Reset:**
  - `wpri` = `rpri` = 0.
  - FIFOs are empty and the in-flight tag is cleared.
  - `rspValid_out` = 0. `wrReady_out`/`rdReady_out` are 0 while `reset_in` is high.
  - RAM contents are not cleared.
  - Reset mid-operation drops in-flight reads and buffered responses, and no write is committed in the reset cycle.

## Timing
- **Write:** accepted at edge *t*, visible to a read issued at *t*+1 or later.
- **Read latency:** acceptance at edge *t* → RAM data registered at *t* → FIFO push at *t*+1. `rspValid_out` is high from *t*+1 through at least the cycle ending at the pop edge, i.e. valid two cycles after the request cycle.
- **Throughput:** one write and one read per cycle aggregate. A single requester with `rspReady_in` held high sustains one read per cycle.
- **Response stability:** `rspData_out` is held stable while `rspValid_out` is high and not popped.

## Configuration
- `RAM_ARB_FWD_EN` defined:
  - When a write and a read to the same row are accepted in the same cycle, the pushed response takes the new write bytes for every lane with its byte enable set, and RAM data for the other lanes.
  - Implemented by registering write data, byte enables and an address-match flag, then muxing bytes at the FIFO push.
- `RAM_ARB_FWD_EN` undefined: pre-write data is returned and no forwarding logic is present.

## Test plan
- **Reset defaults:** reset, then both `wrValid_in` high continuously → grants alternate 0,1,0,1; the first grant goes to requester 0; `rspValid_out` = 0 throughout.
- **Byte-enable write:** write row 3 = `0x1122334455667788` with enables `0xFF`, then row 3 = `0xAAAA…AA` with enables `0x0F`, then read row 3 → `0x11223344AAAAAAAA`.
- **Backpressure:** requester 1 issues reads to rows 0–4 with `rspReady_in[1]` low → exactly 2 reads accepted and `rdReady_out[1]` stays low. Then raise ready → the remaining 3 are accepted and the 5 responses arrive in order.
- **Latency and throughput:** requester 0 issues back-to-back reads with ready high → `rspValid_out[0]` rises at *t*+1 and one response per cycle follows with no bubbles.
- **Read during write:** same-cycle write `0xFF…FF` (enables `0xFF`) and read to row 7, which holds 0 → response 0 without `RAM_ARB_FWD_EN`, `0xFF…FF` with it.
- **Reset mid-operation:** assert reset with 2 responses buffered and 1 in flight → after reset `rspValid_out` = 0, no stale response appears, and the next read returns correct data.
